// File: rtl/bit_counter_shift_reg.sv
// Bit-position counter and load-enabled register for serial-protocol models.
// The counter clears on reset; the register ignores reset and keeps its contents.
module bit_counter_shift_reg #(
    parameter int CNT_WIDTH = 5,
    parameter int REG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cnt_en,
    output logic [CNT_WIDTH-1:0] count,
    input  logic                 reg_en,
    input  logic [REG_WIDTH-1:0] d,
    output logic [REG_WIDTH-1:0] q
);

    logic [CNT_WIDTH-1:0] r_count;
    logic [REG_WIDTH-1:0] r_q;
    logic [CNT_WIDTH-1:0] w_countInc;

    // Natural modulo-2^CNT_WIDTH wrap; the carry-out is simply dropped.
    assign w_countInc = r_count + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (cnt_en) begin
            r_count <= w_countInc;
        end
    end

    // Deliberately reset-less so shifted-in frame data survives a counter reset.
    always_ff @(posedge clk) begin
        if (reg_en) begin
            r_q <= d;
        end
    end

    assign count = r_count;
    assign q     = r_q;

endmodule

// File: tb/tb_bit_counter_shift_reg.sv
// Self-checking bench for bit_counter_shift_reg: a per-cycle model comparison
// plus hand-computed literal expectations from directed vectors.
module tb_bit_counter_shift_reg;

    localparam int CNT_WIDTH = 5;
    localparam int REG_WIDTH = 8;
    localparam int CNT_MOD   = 1 << CNT_WIDTH;

    logic                 clk;
    logic                 reset;
    logic                 cnt_en;
    logic                 reg_en;
    logic [REG_WIDTH-1:0] d;
    logic [CNT_WIDTH-1:0] count;
    logic [REG_WIDTH-1:0] q;

    int                   modelCount;
    bit                   modelCountValid;
    logic [REG_WIDTH-1:0] modelQ;
    bit                   modelQValid;

    int nChecks;
    int nPassed;

    bit_counter_shift_reg #(
        .CNT_WIDTH(CNT_WIDTH),
        .REG_WIDTH(REG_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cnt_en(cnt_en),
        .count (count),
        .reg_en(reg_en),
        .d     (d),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs settle well before the falling edge, so the model is compared there.
    always @(negedge clk) begin
        if (modelCountValid) begin
            nChecks++;
            if (count === CNT_WIDTH'(modelCount)) nPassed++;
            else $display("[TB] FAIL model_count t=%0t actual=%0d required=%0d", $time, count, modelCount);
        end
        if (modelQValid) begin
            nChecks++;
            if (q === modelQ) nPassed++;
            else $display("[TB] FAIL model_q t=%0t actual=0x%02h required=0x%02h", $time, q, modelQ);
        end
    end

    task automatic applyStimulus(input logic r, input logic ce, input logic re, input logic [REG_WIDTH-1:0] dv);
        reset  = r;
        cnt_en = ce;
        reg_en = re;
        d      = dv;
        @(posedge clk);
        if (r) begin
            modelCount      = 0;
            modelCountValid = 1'b1;
        end else if (ce && modelCountValid) begin
            modelCount = (modelCount + 1) % CNT_MOD;
        end
        if (re) begin
            modelQ      = dv;
            modelQValid = 1'b1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        nChecks++;
        if (actual === required) nPassed++;
        else $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    endtask

    initial begin
        logic [7:0] pattern;
        nChecks         = 0;
        nPassed         = 0;
        modelCount      = 0;
        modelCountValid = 1'b0;
        modelQ          = '0;
        modelQValid     = 1'b0;
        reset  = 1'b0;
        cnt_en = 1'b0;
        reg_en = 1'b0;
        d      = '0;
        @(negedge clk);
        #1;

        // Reset then count up to the frame boundary.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("reset_count", 32'(count), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
            checkOutput($sformatf("count_step%0d", i), 32'(count), 32'(i));
        end

        // Wrap from 31 back to 0.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 31; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("count_max", 32'(count), 32'd31);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("count_wrap", 32'(count), 32'd0);

        // Hold at 12, then reset wins over enable.
        for (int i = 1; i <= 12; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("count_12", 32'(count), 32'd12);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF);
            checkOutput($sformatf("count_hold%0d", i), 32'(count), 32'd12);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("reset_priority", 32'(count), 32'd0);

        // Register load, hold against changing d, and survival through reset.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA5);
        checkOutput("q_load", 32'(q), 32'h A5);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h3C);
            checkOutput($sformatf("q_hold%0d", i), 32'(q), 32'hA5);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C);
        checkOutput("q_through_reset", 32'(q), 32'hA5);

        // Shift a byte MSB-first; d is built from the expected register contents.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        pattern = 8'b0000_0001;
        for (int i = 7; i >= 0; i--) applyStimulus(1'b0, 1'b0, 1'b1, {modelQ[6:0], pattern[i]});
        checkOutput("shift_01", 32'(q), 32'h01);
        pattern = 8'b1010_1010;
        for (int i = 7; i >= 0; i--) applyStimulus(1'b0, 1'b0, 1'b1, {modelQ[6:0], pattern[i]});
        checkOutput("shift_AA", 32'(q), 32'hAA);

        // Everything on one edge, starting from a non-zero count.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("count_pre_concurrent", 32'(count), 32'd5);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h5A);
        checkOutput("concurrent_count", 32'(count), 32'd0);
        checkOutput("concurrent_q", 32'(q), 32'h5A);

        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule

// File: doc/bit_counter_shift_reg.md
Name: bit_counter_shift_reg

Overview:
- Datapath primitive pair used by serial-protocol models, e.g. the SPI flash model.
- Sub-function 1 is a WIDTH-bit up-counter with synchronous clear and count enable. It tracks bit position within a serial frame.
- Sub-function 2 is a load-enabled, reset-less register (flopen behaviour). It captures shift-register updates (command, address, data bytes) built externally as {Q[N-2:0], serial_in}.
- Both share one clock and have no combinational path from inputs to outputs.

Parameters:
- CNT_WIDTH, 5, width of the counter (bit index within a 32-bit frame).
- REG_WIDTH, 8, width of the enabled register (8 for command/data, 32 for address).

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  synchronous, active-high; clears the counter only.
- cnt_en  input  1  counter increment enable.
- count  output  CNT_WIDTH  current counter value.
- reg_en  input  1  register load enable.
- d  input  REG_WIDTH  register next-value input.
- q  output  REG_WIDTH  register contents.

Behaviour:
- Clocking: all state updates on the rising edge of clk only. Outputs come straight from flops, so there is zero combinational input-to-output path.

Counter:
- At each rising clk edge:
  - if reset=1: count <= 0;
  - else if cnt_en=1: count <= count + 1 (mod 2^CNT_WIDTH);
  - else: count holds.
- Reset has priority over cnt_en. reset=1 with cnt_en=1 yields 0, not 1.
- Wrap-around: all-ones + 1 -> 0 with no saturation, no carry-out, and no error flag.
- Reset value of count is 0. Value before the first reset is unspecified (X in sim).
- Latency: count reflects an enabled increment or reset one cycle after the edge that samples it.
- Reset mid-count forces 0 on the next edge regardless of the current value.

Register:
- At each rising clk edge:
  - if reg_en=1: q <= d;
  - else: q holds.
- reset has no effect on q. The register retains its contents through reset.
- Power-up value is unspecified (X in sim). Benches must load before checking.
- Shift use: the driver supplies d = {q[REG_WIDTH-2:0], sin_bit}. After REG_WIDTH enabled edges, q holds the bits MSB-first in arrival order.
- d is sampled only on edges where reg_en=1. Changes of d while reg_en=0 are invisible.

Simultaneous events:
- Counter and register operate independently. Any combination of reset, cnt_en and reg_en on the same edge applies each rule above separately.

Not present:
- No asynchronous behaviour.
- No clock gating; enables are pure data-path muxes.

Test Plan:
- Reset then count: reset=1 one edge, then cnt_en=1 for 7 edges -> count = 0,1,...,7 after each edge. The frame boundary (count==7) is reached on the 7th enabled edge.
- Wrap: CNT_WIDTH=5, cnt_en=1 continuously for 32 edges from 0 -> count reaches 31, then returns to 0 on the 32nd edge.
- Hold/priority: count=12, cnt_en=0 for 3 edges -> stays 12. Then reset=1 with cnt_en=1 -> 0 after the edge, never 13.
- Register load/hold: reg_en=1 with d=0xA5 -> q=0xA5. Then reg_en=0 with d=0x3C for 4 edges -> q stays 0xA5. Then assert reset -> q still 0xA5.
- Shift byte: from q=0x00, feed bits 0,0,0,0,0,0,0,1 MSB-first with d={q[6:0],bit} and reg_en=1 -> q=0x01 after 8 edges. Feed pattern 1,0 for 8 edges -> q=0xAA.
- Concurrent: reset=1, cnt_en=1, reg_en=1 with d=0x5A on the same edge -> count=0 and q=0x5A.
